// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each requester gets a one-entry response register. A saturating counter
// records the cycles in which both requesters were eligible at once.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_in1,
  input  logic [WIDTH-1:0]  req0_in2,
  input  logic [CTRL_W-1:0] req0_control,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_in1,
  input  logic [WIDTH-1:0]  req1_in2,
  input  logic [CTRL_W-1:0] req1_control,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_result,
  output logic              rsp1_zero,
  output logic [WIDTH-1:0]  alu_in1,
  output logic [WIDTH-1:0]  alu_in2,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero_flag,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_t;

  prio_t prio;
  prio_t prio_next;
  logic  elig0;
  logic  elig1;
  logic  grant0;
  logic  grant1;

  // Eligibility, grant selection, next priority and ALU operand steering.
  // A requester is eligible when its response slot is empty or being drained
  // this cycle, which lets a refill overlap the consume without a bubble.
  always_comb begin
    elig0       = req0_valid && (!rsp0_valid || rsp0_ready);
    elig1       = req1_valid && (!rsp1_valid || rsp1_ready);
    grant0      = elig0 && (!elig1 || (prio == PRIO_REQ0));
    grant1      = elig1 && !grant0;
    req0_ready  = grant0;
    req1_ready  = grant1;
    prio_next   = prio;
    alu_in1     = '0;
    alu_in2     = '0;
    alu_control = '0;
    if (grant0) begin
      prio_next   = PRIO_REQ1;
      alu_in1     = req0_in1;
      alu_in2     = req0_in2;
      alu_control = req0_control;
    end else if (grant1) begin
      prio_next   = PRIO_REQ0;
      alu_in1     = req1_in1;
      alu_in2     = req1_in2;
      alu_control = req1_control;
    end
  end

  // Round-robin priority pointer; only moves on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PRIO_REQ0;
    end else begin
      prio <= prio_next;
    end
  end

  // Response register for requester 0: capture on grant, else empty on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
    end else if (grant0) begin
      rsp0_valid  <= 1'b1;
      rsp0_result <= alu_result;
      rsp0_zero   <= alu_zero_flag;
    end else if (rsp0_ready) begin
      rsp0_valid  <= 1'b0;
    end
  end

  // Response register for requester 1: capture on grant, else empty on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else if (grant1) begin
      rsp1_valid  <= 1'b1;
      rsp1_result <= alu_result;
      rsp1_zero   <= alu_zero_flag;
    end else if (rsp1_ready) begin
      rsp1_valid  <= 1'b0;
    end
  end

  // Saturating count of cycles where both requesters were eligible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (elig0 && elig1 && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised scoreboard bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]  req0_control, req1_control;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic [3:0]  alu_control;
  logic        alu_zero_flag;
  logic [3:0]  conflict_cnt;

  int tests = 0;
  int fails = 0;

  // Expected {zero, result} per requester, in issue order.
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  // Reference state: priority, response occupancy, counter.
  int   mprio;
  int   mcnt;
  logic mrv0, mrv1;
  logic lg0, lg1;

  // Pending random requests (held until accepted).
  logic        pv0, pv1;
  logic [31:0] pa0, pb0, pa1, pb1;
  logic [3:0]  pc0, pc1;

  logic [3:0] codes [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                            4'b0011, 4'b0101, 4'b0110, 4'b0111};

  alu_arbiter #(.WIDTH(32), .CTRL_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_control(req0_control),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_control(req1_control),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero_flag(alu_zero_flag),
    .conflict_cnt(conflict_cnt)
  );

  function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    logic [31:0] r;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0100: r = a - b;
      4'b1000: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: r = a << b[4:0];
      4'b0101: r = a >> b[4:0];
      4'b0110: r = a * b;
      4'b0111: r = a ^ b;
      default: r = '0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  // External ALU seen by the arbiter.
  always_comb begin
    {alu_zero_flag, alu_result} = alu_ref(alu_in1, alu_in2, alu_control);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    mprio = 0;
    mcnt  = 0;
    mrv0  = 1'b0;
    mrv1  = 1'b0;
    pv0   = 1'b0;
    pv1   = 1'b0;
  endtask

  // One clock cycle: drive at negedge, compare against the rule model, update it.
  task automatic cycle(input logic v0, input logic v1,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                       input logic r0, input logic r1);
    logic e0, e1, g0, g1;
    @(negedge clk);
    req0_valid = v0; req0_in1 = a0; req0_in2 = b0; req0_control = c0;
    req1_valid = v1; req1_in1 = a1; req1_in2 = b1; req1_control = c1;
    rsp0_ready = r0; rsp1_ready = r1;
    #1;
    e0 = v0 && (!mrv0 || r0);
    e1 = v1 && (!mrv1 || r1);
    g0 = e0 && (!e1 || mprio == 0);
    g1 = e1 && !g0;
    chk("req0_ready", 64'(req0_ready), 64'(g0));
    chk("req1_ready", 64'(req1_ready), 64'(g1));
    chk("rsp0_valid", 64'(rsp0_valid), 64'(mrv0));
    chk("rsp1_valid", 64'(rsp1_valid), 64'(mrv1));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(mcnt));
    if (!g0 && !g1) chk("alu_idle", 64'({alu_in1, alu_in2, alu_control}), 64'd0);
    if (g0) q0.push_back(alu_ref(a0, b0, c0));
    if (g1) q1.push_back(alu_ref(a1, b1, c1));
    if (g0) mprio = 1; else if (g1) mprio = 0;
    if (e0 && e1 && mcnt < 15) mcnt++;
    mrv0 = g0 ? 1'b1 : (r0 ? 1'b0 : mrv0);
    mrv1 = g1 ? 1'b1 : (r1 ? 1'b0 : mrv1);
    lg0 = g0;
    lg1 = g1;
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic new_op(output logic [31:0] a, output logic [31:0] b, output logic [3:0] c);
    a = $urandom;
    c = codes[$urandom_range(8)];
    if ($urandom_range(3) == 0) b = a;
    else if ($urandom_range(1) == 0) b = $urandom;
    else b = 32'($urandom_range(40));
  endtask

  // Random step honouring hold-until-accepted; force keeps both requesters valid.
  task automatic rstep(input bit force_valid, input logic r0, input logic r1);
    if (!pv0 && (force_valid || $urandom_range(3) != 0)) begin
      pv0 = 1'b1;
      new_op(pa0, pb0, pc0);
    end
    if (!pv1 && (force_valid || $urandom_range(3) != 0)) begin
      pv1 = 1'b1;
      new_op(pa1, pb1, pc1);
    end
    cycle(pv0, pv1, pa0, pb0, pc0, pa1, pb1, pc1, r0, r1);
    if (lg0) pv0 = 1'b0;
    if (lg1) pv1 = 1'b0;
  endtask

  task automatic idle(input logic r0, input logic r1);
    cycle(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, r0, r1);
  endtask

  // Monitor: every consumed response must match the oldest expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    #2;
    if (rst_n) begin
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) chk("rsp0_unexpected", 64'(rsp0_valid), 64'd0);
        else begin
          e = q0.pop_front();
          chk("rsp0_data", 64'({rsp0_zero, rsp0_result}), 64'(e));
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) chk("rsp1_unexpected", 64'(rsp1_valid), 64'd0);
        else begin
          e = q1.pop_front();
          chk("rsp1_data", 64'({rsp1_zero, rsp1_result}), 64'(e));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_in1 = '0; req0_in2 = '0; req0_control = '0;
    req1_valid = 1'b0; req1_in1 = '0; req1_in2 = '0; req1_control = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'({rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero,
                            req0_ready, req1_ready}), 64'd0);
    chk("reset_results", 64'({rsp0_result, rsp1_result}), 64'd0);
    chk("reset_cnt", 64'(conflict_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full contention from reset: strict alternation starting with requester 0.
    for (int i = 0; i < 6; i++) begin
      rstep(1'b1, 1'b1, 1'b1);
      chk("cont_grant0", 64'(req0_ready), 64'(i % 2 == 0));
    end
    post();
    chk("cont_cnt6", 64'(conflict_cnt), 64'd6);

    // Counter saturation at 2^4-1.
    for (int i = 0; i < 20; i++) rstep(1'b1, 1'b1, 1'b1);
    post();
    chk("cnt_sat", 64'(conflict_cnt), 64'd15);

    // Single ADD on requester 0.
    idle(1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'd5, 32'd3, 4'b0010, '0, '0, '0, 1'b1, 1'b1);
    chk("single_ready", 64'(req0_ready), 64'd1);
    post();
    chk("single_rsp", 64'({rsp0_valid, rsp0_zero, rsp0_result}), {31'd0, 1'b1, 1'b0, 32'd8});

    // Zero flag via SUB, then SLT clears it.
    cycle(1'b0, 1'b1, '0, '0, '0, 32'd7, 32'd7, 4'b0100, 1'b1, 1'b1);
    post();
    chk("sub_zero", 64'({rsp1_valid, rsp1_zero, rsp1_result}), {31'd0, 1'b1, 1'b1, 32'd0});
    cycle(1'b0, 1'b1, '0, '0, '0, 32'd2, 32'd9, 4'b1000, 1'b1, 1'b1);
    post();
    chk("slt_rsp", 64'({rsp1_valid, rsp1_zero, rsp1_result}), {31'd0, 1'b1, 1'b0, 32'd1});

    // Backpressure on requester 0 hands the ALU to requester 1.
    idle(1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'd10, 32'd4, 4'b0100, '0, '0, '0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 32'd20, 32'd22, 4'b0001, 32'd3, 32'd4, 4'b0110, 1'b0, 1'b1);
    chk("bp_block0", 64'({req0_ready, req1_ready}), 64'b01);
    cycle(1'b1, 1'b1, 32'd20, 32'd22, 4'b0001, 32'd6, 32'd6, 4'b0111, 1'b1, 1'b1);
    chk("bp_refill0", 64'(req0_ready), 64'd1);
    post();
    chk("bp_rsp0", 64'({rsp0_valid, rsp0_result}), {31'd0, 1'b1, 32'd22});

    // Asynchronous reset with rsp1 full and priority on requester 1.
    idle(1'b1, 1'b1);
    cycle(1'b0, 1'b1, '0, '0, '0, 32'd1, 32'd1, 4'b0010, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'd9, 32'd1, 4'b0010, '0, '0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    chk("pre_reset_rsp1", 64'(rsp1_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("areset_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    chk("areset_results", 64'({rsp0_result, rsp1_result}), 64'd0);
    chk("areset_cnt", 64'(conflict_cnt), 64'd0);
    model_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 32'd4, 32'd4, 4'b0000, 32'd8, 32'd1, 4'b0011, 1'b1, 1'b1);
    chk("post_reset_grant0", 64'({req0_ready, req1_ready}), 64'b10);

    // Randomised traffic with random drain.
    for (int i = 0; i < 400; i++) begin
      rstep(1'b0, $urandom_range(3) != 0, $urandom_range(3) != 0);
    end
    repeat (3) idle(1'b1, 1'b1);
    chk("drained", 64'(q0.size() + q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
